// File: rtl/s38584_rb_pkg.sv
// Shared constants, FSM state encoding and address-to-pin map for the s38584 readback sequencer.
// The decode map is fixed by the s38584 netlist, so address and capture widths live here.
package s38584_rb_pkg;

    localparam int ADDR_W = 8;
    localparam int CAP_W  = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_SAMPLE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // rb_addr bit i drives netlist input g<RB_PIN_G[i]>
    localparam int RB_PIN_G [ADDR_W] = '{6, 7, 8, 9, 16, 19, 28, 31};

    function automatic int rb_pin(input int addr_bit);
        return RB_PIN_G[addr_bit];
    endfunction

endpackage

// File: rtl/s38584_rr_arbiter.sv
// Round-robin pick among level requests; ptr names the requester with top priority.
// The winner is remembered on accept, and advance moves priority just past it.
module s38584_rr_arbiter
    import s38584_rb_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             accept,
    input  logic             advance,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] won;
    logic [IDX_W-1:0] ptr_nxt;

    always_comb begin
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                idx    = c[IDX_W-1:0];
                gnt[c] = 1'b1;
            end
        end
    end

    always_comb begin
        int n;
        n = int'(won) + 1;
        if (n >= NREQ) n = 0;
        ptr_nxt = n[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            won <= '0;
        end else begin
            if (accept)  won <= idx;
            if (advance) ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/s38584_readback_sequencer.sv
// Shares the s38584 status-readback mux between requesters: walks base..base+len-1,
// holding each address SETTLE cycles, and returns the sampled bits with a done pulse.
module s38584_readback_sequencer
    import s38584_rb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int LEN_W  = 6,
    parameter int SETTLE = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*ADDR_W-1:0]  req_base,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [ADDR_W-1:0]       rb_addr,
    output logic                    rb_en,
    input  logic                    rb_data,
    output logic                    done,
    output logic [IDX_W-1:0]        done_id,
    output logic [CAP_W-1:0]        cap_data
);

    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int CIDX_W = $clog2(CAP_W);
    localparam logic [LEN_W-1:0] CAP_LEN  = LEN_W'(CAP_W);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    state_t            state, nxt;
    logic [IDX_W-1:0]  win, arb_idx;
    logic [NREQ-1:0]   arb_gnt;
    logic [ADDR_W-1:0] base_in;
    logic [LEN_W-1:0]  len_raw, len_in, len_q, idx;
    logic [SET_W-1:0]  cnt;
    logic              req_win, accept, advance;

    assign req_win = req[win];
    assign base_in = req_base[int'(win)*ADDR_W +: ADDR_W];
    assign len_raw = req_len[int'(win)*LEN_W +: LEN_W];
    assign len_in  = (len_raw > CAP_LEN) ? CAP_LEN : len_raw;
    assign accept  = (state == ST_IDLE) && (|req);
    // Aborts advance the pointer too, so a flapping requester cannot starve the others
    assign advance = (state == ST_DONE) || ((state != ST_IDLE) && !req_win);

    s38584_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (CK),
        .rst     (RST),
        .req     (req),
        .accept  (accept),
        .advance (advance),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (|req) nxt = ST_LOAD;
            ST_LOAD:   if (!req_win) nxt = ST_IDLE;
                       else if (len_in == '0) nxt = ST_DONE;
                       else nxt = ST_SETTLE;
            ST_SETTLE: if (!req_win) nxt = ST_IDLE;
                       else if (cnt == SET_LAST) nxt = ST_SAMPLE;
            ST_SAMPLE: if (!req_win) nxt = ST_IDLE;
                       else if (idx == len_q - 1'b1) nxt = ST_DONE;
                       else nxt = ST_SETTLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            win      <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            rb_addr  <= '0;
            rb_en    <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            cap_data <= '0;
            len_q    <= '0;
            idx      <= '0;
            cnt      <= '0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    win  <= arb_idx;
                    gnt  <= arb_gnt;
                    busy <= 1'b1;
                end
                ST_LOAD: if (nxt != ST_IDLE) begin
                    len_q    <= len_in;
                    idx      <= '0;
                    cnt      <= '0;
                    cap_data <= '0;
                    if (nxt == ST_SETTLE) begin
                        rb_en   <= 1'b1;
                        rb_addr <= base_in;
                    end
                end
                ST_SETTLE: if (nxt == ST_SETTLE) cnt <= cnt + 1'b1;
                ST_SAMPLE: if (nxt != ST_IDLE) begin
                    cap_data[idx[CIDX_W-1:0]] <= rb_data;
                    idx <= idx + 1'b1;
                    cnt <= '0;
                    // 8-bit register wraps 0xFF -> 0x00 naturally
                    if (nxt == ST_SETTLE) rb_addr <= rb_addr + 1'b1;
                end
                default: ;
            endcase
            if (nxt == ST_DONE) begin
                done    <= 1'b1;
                done_id <= win;
                rb_en   <= 1'b0;
                rb_addr <= '0;
            end
            if (nxt == ST_IDLE) begin
                gnt     <= '0;
                busy    <= 1'b0;
                rb_en   <= 1'b0;
                rb_addr <= '0;
            end
        end
    end

endmodule
